// File: rtl/audio_sel_pkg.sv
// Shared definitions for the audio source switch.
//   - FSM state encoding of the crossfade sequencer.
//   - Default track-index and volume widths.
package audio_sel_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_SWITCH   = 2'd2;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;

  localparam int DEF_VOL_W = 16;
  localparam int DEF_CUR_W = 3;

endpackage

// File: rtl/vol_ramp.sv
// Combinational saturating volume step.
// Moves i_vol by STEP toward i_limit without overshooting it.
// The result never wraps: arithmetic is done one bit wider than VOL_W.
// Ports:
//   i_up    1      1 = step upward (clamp at i_limit), 0 = step downward (clamp at i_limit)
//   i_vol   VOL_W  present volume
//   i_limit VOL_W  level that must not be crossed
//   o_vol   VOL_W  stepped volume
import audio_sel_pkg::*;

module vol_ramp #(
  parameter int VOL_W = DEF_VOL_W,
  parameter int STEP  = 256
) (
  input  logic             i_up,
  input  logic [VOL_W-1:0] i_vol,
  input  logic [VOL_W-1:0] i_limit,
  output logic [VOL_W-1:0] o_vol
);

  logic [VOL_W:0] w_step;
  logic [VOL_W:0] w_sum;
  logic [VOL_W:0] w_floor;

  assign w_step  = (VOL_W+1)'(STEP);
  assign w_sum   = {1'b0, i_vol} + w_step;
  // Stepping down is only allowed while a full step still lands at or above the limit.
  assign w_floor = {1'b0, i_limit} + w_step;

  always_comb begin
    if (i_up) begin
      o_vol = (w_sum > {1'b0, i_limit}) ? i_limit : w_sum[VOL_W-1:0];
    end else begin
      o_vol = ({1'b0, i_vol} >= w_floor) ? (i_vol - w_step[VOL_W-1:0]) : i_limit;
    end
  end

endmodule

// File: rtl/audio_source_switch.sv
// N-source selector for the playback path with a click-free volume crossfade.
// A source change ramps the volume out to zero, switches the active source for
// one cycle, then ramps in to the new source's live volume. Out-of-range selects
// are ignored. After reset the block soft-starts by fading in source 0.
// Optional feature macro: AUDIO_SEL_MUTE_EN (adds the mute input).
// Ports:
//   clk          1              system clock, rising edge
//   rst_n        1              asynchronous active-low reset
//   sel          SEL_W          requested source index
//   src_current  NUM_SRC*CUR_W  packed track indices, source k at [k*CUR_W +: CUR_W]
//   src_volume   NUM_SRC*VOL_W  packed volumes, source k at [k*VOL_W +: VOL_W]
//   mute         1              (AUDIO_SEL_MUTE_EN only) fade to zero and hold
//   current      CUR_W          track index of the active source (registered)
//   volume       VOL_W          ramped output volume (registered)
//   active_sel   SEL_W          source currently driving the outputs
//   busy         1              high whenever the sequencer is not idle
module audio_source_switch
  import audio_sel_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int CUR_W    = DEF_CUR_W,
  parameter int VOL_W    = DEF_VOL_W,
  parameter int STEP     = 256,
  parameter int TICK_DIV = 4,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*CUR_W-1:0] src_current,
  input  logic [NUM_SRC*VOL_W-1:0] src_volume,
`ifdef AUDIO_SEL_MUTE_EN
  input  logic                     mute,
`endif
  output logic [CUR_W-1:0]         current,
  output logic [VOL_W-1:0]         volume,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]        r_state;
  logic [TICK_W-1:0] r_tick;
  logic [VOL_W-1:0]  r_vol;
  logic [CUR_W-1:0]  r_cur;
  logic [SEL_W-1:0]  r_asel;
  logic [SEL_W-1:0]  r_tgt;

  logic [VOL_W-1:0]  w_vol_arr [NUM_SRC];
  logic [CUR_W-1:0]  w_cur_arr [NUM_SRC];
  logic [VOL_W-1:0]  w_lvl;
  logic [CUR_W-1:0]  w_src_cur;
  logic [VOL_W-1:0]  w_up;
  logic [VOL_W-1:0]  w_dn;
  logic [SEL_W-1:0]  w_tgt_nxt;
  logic              w_sel_ok;
  logic              w_sel_chg;
  logic              w_sel_back;
  logic              w_step;
  logic              w_mute;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign w_vol_arr[k] = src_volume[k*VOL_W +: VOL_W];
    assign w_cur_arr[k] = src_current[k*CUR_W +: CUR_W];
  end

`ifdef AUDIO_SEL_MUTE_EN
  assign w_mute = mute;
`else
  assign w_mute = 1'b0;
`endif

  assign w_lvl      = w_vol_arr[r_asel];
  assign w_src_cur  = w_cur_arr[r_asel];
  assign w_sel_ok   = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
  assign w_sel_chg  = w_sel_ok && (sel != r_asel);
  assign w_sel_back = w_sel_ok && (sel == r_asel);
  assign w_tgt_nxt  = w_sel_ok ? sel : r_tgt;
  assign w_step     = (r_tick == TICK_LAST);

  vol_ramp #(.VOL_W(VOL_W), .STEP(STEP)) u_ramp_up (
    .i_up    (1'b1),
    .i_vol   (r_vol),
    .i_limit (w_lvl),
    .o_vol   (w_up)
  );

  vol_ramp #(.VOL_W(VOL_W), .STEP(STEP)) u_ramp_dn (
    .i_up    (1'b0),
    .i_vol   (r_vol),
    .i_limit ('0),
    .o_vol   (w_dn)
  );

  // Every branch that changes r_state also clears r_tick; the later assignment wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FADE_IN;
      r_tick  <= '0;
      r_vol   <= '0;
      r_cur   <= '0;
      r_asel  <= '0;
      r_tgt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_vol  <= w_lvl;
          r_cur  <= w_src_cur;
          r_tick <= '0;
          if (w_sel_chg) begin
            r_tgt   <= sel;
            r_state <= ST_FADE_OUT;
          end else if (w_mute) begin
            r_tgt   <= r_asel;
            r_state <= ST_FADE_OUT;
          end
        end
        ST_FADE_OUT: begin
          r_tick <= w_step ? '0 : r_tick + 1'b1;
          // Target equal to the active source only happens while muted; leaving
          // mute in that situation resumes on the same source without a switch.
          if (!w_mute && (w_sel_back || (r_tgt == r_asel))) begin
            r_state <= ST_FADE_IN;
            r_tick  <= '0;
          end else begin
            r_tgt <= w_tgt_nxt;
            if (w_step) begin
              r_vol <= w_dn;
            end
            if (((r_vol == '0) || (w_step && (w_dn == '0))) && (w_tgt_nxt != r_asel)) begin
              r_state <= ST_SWITCH;
              r_tick  <= '0;
            end
          end
        end
        ST_SWITCH: begin
          r_asel  <= r_tgt;
          r_cur   <= w_cur_arr[r_tgt];
          r_vol   <= '0;
          r_tick  <= '0;
          r_state <= ST_FADE_IN;
        end
        ST_FADE_IN: begin
          r_cur  <= w_src_cur;
          r_tick <= w_step ? '0 : r_tick + 1'b1;
          if (w_sel_chg) begin
            r_tgt   <= sel;
            r_state <= ST_FADE_OUT;
            r_tick  <= '0;
          end else if (w_mute) begin
            r_tgt   <= r_asel;
            r_state <= ST_FADE_OUT;
            r_tick  <= '0;
          end else if (w_lvl <= r_vol) begin
            // Covers both reaching the level and the live level dropping below us.
            r_vol   <= w_lvl;
            r_state <= ST_IDLE;
            r_tick  <= '0;
          end else if (w_step) begin
            r_vol <= w_up;
            if (w_up == w_lvl) begin
              r_state <= ST_IDLE;
              r_tick  <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign current    = r_cur;
  assign volume     = r_vol;
  assign active_sel = r_asel;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_audio_source_switch.sv
module tb_audio_source_switch;

  localparam int NUM_SRC  = 5;
  localparam int CUR_W    = 3;
  localparam int VOL_W    = 16;
  localparam int STEP     = 256;
  localparam int TICK_DIV = 4;
  localparam int SEL_W    = 3;

  localparam int P_SETTLED = 10;
  localparam int P_OUT     = 20;
  localparam int P_SWAP    = 30;
  localparam int P_IN      = 40;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*CUR_W-1:0] src_current;
  logic [NUM_SRC*VOL_W-1:0] src_volume;
  logic [CUR_W-1:0]         current;
  logic [VOL_W-1:0]         volume;
  logic [SEL_W-1:0]         active_sel;
  logic                     busy;

  logic [VOL_W-1:0] tb_vol [NUM_SRC];
  logic [CUR_W-1:0] tb_cur [NUM_SRC];

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    int phase;
    int age;
    int vol;
    int cur;
    int act;
    int tgt;
  } mst_t;

  mst_t m;

  audio_source_switch #(
    .NUM_SRC  (NUM_SRC),
    .CUR_W    (CUR_W),
    .VOL_W    (VOL_W),
    .STEP     (STEP),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .src_current (src_current),
    .src_volume  (src_volume),
`ifdef AUDIO_SEL_MUTE_EN
    .mute        (1'b0),
`endif
    .current     (current),
    .volume      (volume),
    .active_sel  (active_sel),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_volume  = '0;
    src_current = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_volume[k*VOL_W +: VOL_W]  = tb_vol[k];
      src_current[k*CUR_W +: CUR_W] = tb_cur[k];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mst_t mreset();
    mst_t r;
    r.phase = P_IN;
    r.age   = 0;
    r.vol   = 0;
    r.cur   = 0;
    r.act   = 0;
    r.tgt   = 0;
    return r;
  endfunction

  // One clock of the crossfade rules, applied to the inputs present before the edge.
  function automatic mst_t mstep(input mst_t c);
    mst_t n;
    int   s;
    int   lvl;
    bit   valid;
    bit   hit;
    n     = c;
    s     = int'(sel);
    valid = (s < NUM_SRC);
    hit   = ((c.age % TICK_DIV) == (TICK_DIV - 1));
    lvl   = int'(tb_vol[c.act]);
    case (c.phase)
      P_SETTLED: begin
        n.vol = lvl;
        n.cur = int'(tb_cur[c.act]);
        if (valid && s != c.act) begin
          n.tgt   = s;
          n.phase = P_OUT;
        end
      end
      P_OUT: begin
        if (valid && s == c.act) begin
          n.phase = P_IN;
        end else begin
          if (valid) n.tgt = s;
          if (c.vol == 0) begin
            n.phase = P_SWAP;
          end else if (hit) begin
            n.vol = (c.vol > STEP) ? c.vol - STEP : 0;
            if (n.vol == 0) n.phase = P_SWAP;
          end
        end
      end
      P_SWAP: begin
        n.act   = c.tgt;
        n.cur   = int'(tb_cur[c.tgt]);
        n.vol   = 0;
        n.phase = P_IN;
      end
      default: begin
        n.cur = int'(tb_cur[c.act]);
        if (valid && s != c.act) begin
          n.tgt   = s;
          n.phase = P_OUT;
        end else if (lvl <= c.vol) begin
          n.vol   = lvl;
          n.phase = P_SETTLED;
        end else if (hit) begin
          n.vol = (c.vol + STEP < lvl) ? c.vol + STEP : lvl;
          if (n.vol == lvl) n.phase = P_SETTLED;
        end
      end
    endcase
    n.age = (n.phase != c.phase) ? 0 : c.age + 1;
    return n;
  endfunction

  initial begin
    m = mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m = mreset();
      else        m = mstep(m);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("volume",     int'(volume),     m.vol);
        chk("current",    int'(current),    m.cur);
        chk("active_sel", int'(active_sel), m.act);
        chk("busy",       int'(busy),       int'(m.phase != P_SETTLED));
      end
    end
  end

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    sel   = '0;
    tb_vol[0] = 16'h0400; tb_cur[0] = 3'd2;
    tb_vol[1] = 16'h0100; tb_cur[1] = 3'd7;
    tb_vol[2] = 16'h0200; tb_cur[2] = 3'd5;
    tb_vol[3] = 16'h0250; tb_cur[3] = 3'd1;
    tb_vol[4] = 16'h0180; tb_cur[4] = 3'd4;
    nx(2);
    chk("rst_volume",  int'(volume),     0);
    chk("rst_current", int'(current),    0);
    chk("rst_asel",    int'(active_sel), 0);
    chk("rst_busy",    int'(busy),       1);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    // Soft start on source 0.
    nx(4);  chk("start_step1", int'(volume), 'h100);
    nx(4);  chk("start_step2", int'(volume), 'h200);
    nx(4);  chk("start_step3", int'(volume), 'h300);
    nx(4);  chk("start_step4", int'(volume), 'h400);
    chk("start_idle", int'(busy), 0);

    // Idle tracking, then a full crossfade 0 -> 2.
    tb_vol[0] = 16'h0300;
    nx(3);  chk("idle_track", int'(volume), 'h300);
    sel = 3'd2;
    nx(5);  chk("out_step1", int'(volume), 'h200);
    nx(8);  chk("out_zero", int'(volume), 0);
    chk("out_asel_held", int'(active_sel), 0);
    nx(1);  chk("sw_asel", int'(active_sel), 2);
    chk("sw_current", int'(current), 5);
    nx(8);  chk("in_done", int'(volume), 'h200);
    chk("in_idle", int'(busy), 0);

    // Back to source 0, then a cancelled switch.
    sel = 3'd0;
    nx(24); chk("back0_vol", int'(volume), 'h300);
    sel = 3'd1;
    nx(5);  chk("cancel_mid", int'(volume), 'h200);
    sel = 3'd0;
    nx(5);  chk("cancel_vol", int'(volume), 'h300);
    chk("cancel_asel", int'(active_sel), 0);
    chk("cancel_cur", int'(current), 2);
    chk("cancel_idle", int'(busy), 0);

    // Out-of-range select is ignored; then clamp to an odd target level.
    sel = 3'd5;
    nx(6);  chk("bad_sel_busy", int'(busy), 0);
    sel = 3'd3;
    nx(26); chk("clamp_vol", int'(volume), 'h250);
    chk("clamp_idle", int'(busy), 0);

    // Asynchronous reset in the middle of a fade-in.
    tb_vol[1] = 16'h0300;
    sel = 3'd1;
    nx(22); chk("pre_rst_vol", int'(volume), 'h200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_volume",  int'(volume),     0);
    chk("arst_current", int'(current),    0);
    chk("arst_asel",    int'(active_sel), 0);
    chk("arst_busy",    int'(busy),       1);
    nx(2);
    rst_n = 1'b1;
    nx(1);  chk("post_rst_busy", int'(busy), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      nx(1);
      if ($urandom_range(0, 39) == 0) sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) begin
        k = int'($urandom_range(0, NUM_SRC - 1));
        case ($urandom_range(0, 9))
          0:       tb_vol[k] = 16'hFFF0 - 16'($urandom_range(0, 3));
          1:       tb_vol[k] = 16'h0000;
          2, 3, 4: tb_vol[k] = 16'($urandom_range(0, 8) * 256);
          default: tb_vol[k] = 16'($urandom_range(0, 16'h0900));
        endcase
        tb_cur[k] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        nx(1);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
